stream_capture_buffer: RTL and testbench

Synthesizable, parametrised stream sink that captures valid/ready/last beats into an on-chip buffer for host readback. Generalises the 32-bit sim-only stream writer to any data width and depth, adding flow-control modes, packet counting, a packet-limit stop, and overflow reporting. Sits at the tail of the RX DMA path as the capture point for bring-up and test data.

---
 rtl/stream_capture_buffer.sv | 86 ++++++++
 tb/tb_stream_capture_buffer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_capture_buffer.sv
// stream_capture_buffer: captures valid/ready/last stream beats into a circular buffer for host readback,
// with stall/drop flow control, packet counting, a packet-limit stop and overflow reporting.
module stream_capture_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int MODE   = 0,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              clear,
   input  logic [15:0]       pkt_limit,
   input  logic              s_valid,
   input  logic              s_last,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   input  logic              rd_en,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic [CNT_W-1:0]  word_count,
   output logic [15:0]       pkt_count,
   output logic [15:0]       drop_count,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic              done
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
   state_t          state;
   logic [DATA_W:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            acc, wr, drp, pop, hit;
   assign full    = word_count == CNT_W'(DEPTH);
   assign empty   = word_count == '0;
   assign done    = state == DONE;
   // fullness is the registered count, so a same-cycle pop never admits a write
   assign s_ready = (state == CAPTURE) && enable && (MODE != 0 || !full);
   assign acc     = s_valid & s_ready;
   assign wr      = acc & !full;
   assign drp     = acc & full;
   assign pop     = rd_en & !empty;
   assign hit     = wr & s_last & (pkt_limit != 16'd0) &
                    (({1'b0, pkt_count} + 17'd1) == {1'b0, pkt_limit});
   always_ff @(posedge clk)
      if (wr && !clear) mem[wr_ptr] <= {s_last, s_data};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         word_count <= '0;
         pkt_count  <= '0;
         drop_count <= '0;
         overflow   <= 1'b0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
         rd_last    <= 1'b0;
      end else if (clear) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         word_count <= '0;
         pkt_count  <= '0;
         drop_count <= '0;
         overflow   <= 1'b0;
         rd_valid   <= 1'b0;
      end else begin
         case (state)
            IDLE:    state <= enable ? CAPTURE : IDLE;
            CAPTURE: state <= hit ? DONE : (enable ? CAPTURE : IDLE);
            default: state <= enable ? DONE : IDLE;
         endcase
         if (wr) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         word_count <= word_count + CNT_W'(wr) - CNT_W'(pop);
         if (wr && s_last && pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
         if (drp && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         if (drp) overflow <= 1'b1;
         rd_valid <= pop;
         if (pop) {rd_last, rd_data} <= mem[rd_ptr];
      end
   end
endmodule

// File: tb/tb_stream_capture_buffer.sv
// tb_stream_capture_buffer: directed checks of a STALL and a DROP instance (DEPTH=8) driven by shared stimulus.
module tb_stream_capture_buffer;
   logic        clk = 0, rst = 1, enable = 0, clear = 0, s_valid = 0, s_last = 0, rd_en = 0;
   logic [15:0] pkt_limit = 0;
   logic [31:0] s_data = 0;
   logic        st_s_ready, st_rd_valid, st_rd_last, st_full, st_empty, st_overflow, st_done;
   logic [31:0] st_rd_data;
   logic [3:0]  st_wc;
   logic [15:0] st_pkt, st_drop;
   logic        dr_s_ready, dr_rd_valid, dr_rd_last, dr_full, dr_empty, dr_overflow, dr_done;
   logic [31:0] dr_rd_data;
   logic [3:0]  dr_wc;
   logic [15:0] dr_pkt, dr_drop;
   int          n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   stream_capture_buffer #(.DATA_W(32), .DEPTH(8), .MODE(0)) u_st (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear), .pkt_limit(pkt_limit),
      .s_valid(s_valid), .s_last(s_last), .s_data(s_data), .s_ready(st_s_ready),
      .rd_en(rd_en), .rd_valid(st_rd_valid), .rd_data(st_rd_data), .rd_last(st_rd_last),
      .word_count(st_wc), .pkt_count(st_pkt), .drop_count(st_drop), .full(st_full),
      .empty(st_empty), .overflow(st_overflow), .done(st_done));

   stream_capture_buffer #(.DATA_W(32), .DEPTH(8), .MODE(1)) u_dr (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear), .pkt_limit(pkt_limit),
      .s_valid(s_valid), .s_last(s_last), .s_data(s_data), .s_ready(dr_s_ready),
      .rd_en(rd_en), .rd_valid(dr_rd_valid), .rd_data(dr_rd_data), .rd_last(dr_rd_last),
      .word_count(dr_wc), .pkt_count(dr_pkt), .drop_count(dr_drop), .full(dr_full),
      .empty(dr_empty), .overflow(dr_overflow), .done(dr_done));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      chk("rst_wc", 32'(st_wc), 0);
      chk("rst_empty", 32'(st_empty), 1);
      chk("rst_full", 32'(st_full), 0);
      chk("rst_sready", 32'(st_s_ready), 0);
      chk("rst_rdvalid", 32'(st_rd_valid), 0);
      chk("rst_rddata", st_rd_data, 0);
      chk("rst_done", 32'(st_done), 0);
      chk("rst_ovf", 32'(dr_overflow), 0);
      tick();
      rst = 0;
      // STALL: fill to 8, stall, pop in order
      enable = 1;
      tick();
      s_valid = 1;
      for (int i = 0; i < 8; i++) begin
         s_data = 32'(i);
         chk("st_fill_ready", 32'(st_s_ready), 1);
         tick();
      end
      s_data = 32'h8;
      chk("st_full", 32'(st_full), 1);
      chk("st_wc8", 32'(st_wc), 8);
      chk("st_stall_ready", 32'(st_s_ready), 0);
      tick();
      tick();
      chk("st_wc8_hold", 32'(st_wc), 8);
      s_valid = 0;
      rd_en = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("st_pop_valid", 32'(st_rd_valid), 1);
         chk("st_pop_data", st_rd_data, 32'(i));
         chk("st_pop_last", 32'(st_rd_last), 0);
      end
      tick();
      chk("st_empty_pop_valid", 32'(st_rd_valid), 0);
      chk("st_empty_pop_hold", st_rd_data, 32'h7);
      chk("st_empty", 32'(st_empty), 1);
      rd_en = 0;
      s_valid = 1;
      s_data = 32'h8;
      tick();
      s_data = 32'h9;
      tick();
      s_valid = 0;
      chk("st_rest_wc", 32'(st_wc), 2);
      // DROP: 11 pushes, 3 dropped
      clear = 1;
      tick();
      chk("clr_wc", 32'(dr_wc), 0);
      chk("clr_ovf", 32'(dr_overflow), 0);
      clear = 0;
      tick();
      s_valid = 1;
      for (int i = 0; i < 11; i++) begin
         s_data = 32'h10 + 32'(i);
         chk("dr_ready", 32'(dr_s_ready), 1);
         tick();
      end
      s_valid = 0;
      chk("dr_wc", 32'(dr_wc), 8);
      chk("dr_drop", 32'(dr_drop), 3);
      chk("dr_ovf", 32'(dr_overflow), 1);
      chk("dr_full", 32'(dr_full), 1);
      rd_en = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("dr_pop_valid", 32'(dr_rd_valid), 1);
         chk("dr_pop_data", dr_rd_data, 32'h10 + 32'(i));
      end
      rd_en = 0;
      // packet limit 2 on packets of 3, 2, 4 beats
      clear = 1;
      tick();
      clear = 0;
      pkt_limit = 16'd2;
      tick();
      s_valid = 1;
      for (int k = 0; k < 5; k++) begin
         s_data = 32'h20 + 32'(k);
         s_last = (k == 2 || k == 4);
         chk("pk_ready", 32'(st_s_ready), 1);
         tick();
      end
      chk("pk_done", 32'(st_done), 1);
      chk("pk_count", 32'(st_pkt), 2);
      chk("pk_sready", 32'(st_s_ready), 0);
      chk("pk_wc", 32'(st_wc), 5);
      for (int k = 5; k < 9; k++) begin
         s_data = 32'h20 + 32'(k);
         s_last = (k == 8);
         tick();
      end
      s_valid = 0;
      s_last = 0;
      chk("pk_wc_hold", 32'(st_wc), 5);
      chk("pk_done_hold", 32'(st_done), 1);
      chk("pk_dr_done", 32'(dr_done), 1);
      enable = 0;
      tick();
      chk("pk_done_off", 32'(st_done), 0);
      pkt_limit = 0;
      // simultaneous push/pop at occupancy 4 across pointer wrap
      clear = 1;
      enable = 1;
      tick();
      clear = 0;
      tick();
      s_valid = 1;
      for (int k = 0; k < 4; k++) begin
         s_data = 32'h40 + 32'(k);
         s_last = (k % 3 == 2);
         tick();
      end
      chk("sp_wc4", 32'(st_wc), 4);
      rd_en = 1;
      for (int j = 0; j < 20; j++) begin
         s_data = 32'h44 + 32'(j);
         s_last = ((j + 4) % 3 == 2);
         tick();
         chk("sp_valid", 32'(st_rd_valid), 1);
         chk("sp_data", st_rd_data, 32'h40 + 32'(j));
         chk("sp_last", 32'(st_rd_last), 32'(j % 3 == 2));
         chk("sp_wc", 32'(st_wc), 4);
      end
      rd_en = 0;
      s_data = 32'h58;
      s_last = 0;
      tick();
      chk("cl_wc5", 32'(st_wc), 5);
      // clear collides with write and pop
      s_data = 32'h59;
      rd_en = 1;
      clear = 1;
      tick();
      chk("cl_wc", 32'(st_wc), 0);
      chk("cl_empty", 32'(st_empty), 1);
      chk("cl_pkt", 32'(st_pkt), 0);
      chk("cl_rdvalid", 32'(st_rd_valid), 0);
      chk("cl_rddata_hold", st_rd_data, 32'h53);
      chk("cl_idle_sready", 32'(st_s_ready), 0);
      clear = 0;
      rd_en = 0;
      s_valid = 0;
      // async reset mid-packet
      tick();
      s_valid = 1;
      s_data = 32'h60;
      tick();
      s_data = 32'h61;
      tick();
      chk("ar_wc2", 32'(st_wc), 2);
      #3 rst = 1;
      #1;
      chk("ar_wc", 32'(st_wc), 0);
      chk("ar_empty", 32'(st_empty), 1);
      chk("ar_sready", 32'(st_s_ready), 0);
      chk("ar_dr_sready", 32'(dr_s_ready), 0);
      chk("ar_rddata", st_rd_data, 0);
      chk("ar_pkt", 32'(st_pkt), 0);
      s_valid = 0;
      tick();
      rst = 0;
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
